// File: rtl/clk_gen_multi.sv
// Multi-channel divided-clock generator with per-channel divide/phase and a PLL-style locked flag.
// All outputs are registered from the counter values written on the same edge.
module clk_gen_multi #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 16,
  parameter int DEF_DIV     = 4,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_CH*CNT_W-1:0] cfg_div,
  input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
  input  logic                    cfg_load,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick_out,
  output logic                    locked
);

  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DIV_MIN   = CNT_W'(2);
  localparam logic [CNT_W-1:0]  DIV_RST   = CNT_W'(DEF_DIV);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOCKING = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [LOCK_W-1:0] lock_cnt_reg, lock_cnt_next;
  logic              run_next;
  logic              locked_reg;

  logic [CNT_W-1:0] div_reg   [NUM_CH];
  logic [CNT_W-1:0] div_next  [NUM_CH];
  logic [CNT_W-1:0] phase_reg [NUM_CH];
  logic [CNT_W-1:0] phase_next[NUM_CH];
  logic [CNT_W-1:0] cnt_reg   [NUM_CH];
  logic [CNT_W-1:0] cnt_next  [NUM_CH];
  logic [NUM_CH-1:0] clk_out_reg, clk_out_next;
  logic [NUM_CH-1:0] tick_out_reg, tick_out_next;

  // en has priority over cfg_load; a load while running always restarts the lock count.
  always_comb begin
    state_next    = state_reg;
    lock_cnt_next = lock_cnt_reg;
    if (!en) begin
      state_next    = ST_IDLE;
      lock_cnt_next = '0;
    end else if (cfg_load) begin
      state_next    = ST_LOCKING;
      lock_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next    = ST_LOCKING;
          lock_cnt_next = '0;
        end
        ST_LOCKING: begin
          if (lock_cnt_reg == LOCK_LAST) begin
            state_next = ST_LOCKED;
          end else begin
            lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
          end
        end
        ST_LOCKED: state_next = ST_LOCKED;
        default: begin
          state_next    = ST_IDLE;
          lock_cnt_next = '0;
        end
      endcase
    end
  end

  assign run_next = (state_next != ST_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] div_raw, phase_raw, div_eff, phase_eff;

      assign div_raw   = cfg_div[gi*CNT_W +: CNT_W];
      assign phase_raw = cfg_phase[gi*CNT_W +: CNT_W];
      assign div_eff   = (div_raw < DIV_MIN) ? DIV_MIN : div_raw;
      assign phase_eff = (phase_raw < div_eff) ? phase_raw : '0;

      assign div_next[gi]   = cfg_load ? div_eff : div_reg[gi];
      assign phase_next[gi] = cfg_load ? phase_eff : phase_reg[gi];

      // Counter parks at the start phase whenever the channel is not free-running.
      always_comb begin
        cnt_next[gi] = cnt_reg[gi];
        if (!en || cfg_load || (state_reg == ST_IDLE)) begin
          cnt_next[gi] = phase_next[gi];
        end else if (cnt_reg[gi] == div_reg[gi] - CNT_W'(1)) begin
          cnt_next[gi] = '0;
        end else begin
          cnt_next[gi] = cnt_reg[gi] + CNT_W'(1);
        end
      end

      // Outputs decode the value being written now, so they lead the counter by no cycle.
      assign clk_out_next[gi]  = run_next && (cnt_next[gi] < (div_next[gi] >> 1));
      assign tick_out_next[gi] = run_next && (cnt_next[gi] == '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      lock_cnt_reg <= '0;
      locked_reg   <= 1'b0;
      clk_out_reg  <= '0;
      tick_out_reg <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_reg[i]   <= DIV_RST;
        phase_reg[i] <= '0;
        cnt_reg[i]   <= '0;
      end
    end else begin
      state_reg    <= state_next;
      lock_cnt_reg <= lock_cnt_next;
      locked_reg   <= (state_next == ST_LOCKED);
      clk_out_reg  <= clk_out_next;
      tick_out_reg <= tick_out_next;
      for (int i = 0; i < NUM_CH; i++) begin
        div_reg[i]   <= div_next[i];
        phase_reg[i] <= phase_next[i];
        cnt_reg[i]   <= cnt_next[i];
      end
    end
  end

  assign clk_out  = clk_out_reg;
  assign tick_out = tick_out_reg;
  assign locked   = locked_reg;

endmodule

// File: doc/clk_gen_multi.md
# clk_gen_multi

Parametrised multi-channel digital clock generator. It is the fabric-side counterpart to the vendor clocking wizard. From one input clock it produces NUM_CH divided clocks, each with its own runtime divide ratio and phase offset, plus per-channel single-cycle strobes. A `locked` indication tracks reconfiguration the way the PLL's `locked` does. Downstream logic gates on `locked` exactly as it does for the PLL.

## Interface
Parameters:
- NUM_CH, 2, number of output channels (1..8)
- CNT_W, 16, width of divide and phase fields per channel
- DEF_DIV, 4, divide ratio loaded into every channel at reset
- LOCK_CYCLES, 16, cycles from (re)start until `locked` asserts (>=1)

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; 0 parks all channels
- cfg_div  in  NUM_CH*CNT_W  per-channel divide ratio D, channel i at bits [i*CNT_W +: CNT_W]
- cfg_phase  in  NUM_CH*CNT_W  per-channel start count P, same packing
- cfg_load  in  1  one-cycle strobe; latches cfg_div/cfg_phase into shadow registers and restarts all channels
- clk_out  out  NUM_CH  divided clock per channel, registered
- tick_out  out  NUM_CH  one-cycle strobe per channel at counter wrap, registered
- locked  out  1  high when all channels run a stable, committed configuration

## Operation
- Reset (rst_n=0, async) sets the following values:
  - shadow D = DEF_DIV and P = 0 for all channels
  - counters = 0, state IDLE, lock counter = 0
  - clk_out = 0, tick_out = 0, locked = 0
- Shadow sanitising is applied at load. Effective D = max(cfg_div, 2). Effective P = cfg_phase if cfg_phase < D, else 0.
- Per-channel counter cnt counts 0..D-1 and wraps to 0. It advances only in LOCKING or LOCKED.
- clk_out[i] = 1 when cnt < (D>>1), else 0.
  - Even D gives 50 % duty.
  - Odd D gives floor(D/2) high cycles out of D.
- tick_out[i] = 1 for exactly the cycle in which cnt == 0.
- clk_out and tick_out are registered from the same counter value, so they are mutually aligned.
- States:
  - IDLE: counters held at P, clk_out = tick_out = 0, locked = 0. Goes to LOCKING when en=1.
  - LOCKING: counters run, lock counter increments each cycle, locked = 0. Goes to LOCKED when the lock counter reaches LOCK_CYCLES-1.
  - LOCKED: counters run, locked = 1.
  - From any state, en=0 goes to IDLE. Counters reload P and the lock counter clears.
- cfg_load (when en=1, any state):
  - commits shadows
  - sets every cnt = new P
  - clears the lock counter
  - enters LOCKING, with locked dropping the next cycle
- cfg_load with en=0 commits shadows only; the state stays IDLE.
- cfg_load together with en falling: en wins. The shadows are still committed.
- cfg_load repeated during LOCKING restarts the lock count.

## Timing
- Registered outputs reflect the counter state written at the same edge. There is no combinational path from any input to any output.
- en rising is sampled at edge k:
  - at edge k: state = LOCKING, cnt = P (held value)
  - at edge k+1: cnt = P+1 (mod D)
  - outputs for cycle k..k+1 decode cnt = P
- locked is 1 from edge k+LOCK_CYCLES onward while en stays high and no cfg_load occurs.
- cfg_load is sampled at edge k:
  - cnt = P' at edge k
  - locked = 0 from edge k
  - locked = 1 again at edge k+LOCK_CYCLES
- Channels sharing D and P are cycle-identical. All channels restart on the same edge.
- Counter compare and wrap use the full CNT_W. D = 2^CNT_W-1 must wrap correctly with no overflow.
- Async reset mid-operation forces all outputs low immediately, independent of clk.

## Test plan
- Reset, en=1, defaults: D=4 on both channels. clk_out = 1100 repeating, tick_out every 4th cycle. locked rises exactly 16 cycles after en.
- cfg_load with ch0 D=3 P=0 and ch1 D=6 P=2:
  - ch0 clk_out = 100 repeating
  - ch1 clk_out starts 1 0 0 0 1 1 …
  - ch1 first tick 4 cycles after load
  - locked drops, then re-asserts after 16 cycles
- Sanitising: cfg_div=0 yields D=2 (toggles every cycle). cfg_phase=9 with D=5 yields P=0.
- cfg_load issued every 10 cycles with LOCK_CYCLES=16: locked never asserts. After the loads stop, locked asserts 16 cycles after the last load.
- en dropped while LOCKED: the next edge gives outputs 0 and locked=0. en re-raised: counters resume from P and lock takes 16 cycles again.
- rst_n pulsed low mid-cycle during LOCKED: all outputs go 0 asynchronously, D reverts to DEF_DIV, and the block relocks after release.
